// File: rtl/uart_rx_os_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_rx_os_fifo_if
//   Bundles the serial input and the FIFO read side of uart_rx_os_fifo.
//   master : the consumer/line side (drives rxd and rd_en)
//   slave  : the receiver itself
//   Signals:
//     rxd       serial line, idle high, asynchronous to clk
//     rd_en     pop the head byte this cycle (ignored when empty)
//     data      FIFO head byte, show-ahead, valid while empty=0
//     empty     FIFO holds no bytes
//     full      FIFO holds FIFO_DEPTH bytes
//     count     bytes currently held, 0..FIFO_DEPTH
//     frame_err 1-cycle pulse: stop bit sampled low
//     overrun   1-cycle pulse: good byte dropped because FIFO was full
//   FIFO_DEPTH must match the receiver's FIFO_DEPTH so count widths agree.
// ----------------------------------------------------------------------------
interface uart_rx_os_fifo_if #(
    parameter int FIFO_DEPTH = 16
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rxd;
    logic          rd_en;
    logic [7:0]    data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overrun;

    modport master (
        output rxd, rd_en,
        input  data, empty, full, count, frame_err, overrun
    );

    modport slave (
        input  rxd, rd_en,
        output data, empty, full, count, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_os_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_os_fifo
//   8N1 UART receiver with OVERSAMPLE x oversampling, mid-bit sampling and a
//   show-ahead byte FIFO. All timing is derived from clk via a tick divider.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  uart_rx_os_fifo_if.slave (rxd, rd_en, data, empty, full, count,
//          frame_err, overrun)
// ----------------------------------------------------------------------------
module uart_rx_os_fifo #(
    parameter int CLOCK_FREQ = 12000000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_rx_os_fifo_if.slave    bus
);
    localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- synchroniser and tick divider ----------------
    logic [1:0]    sync_q;
    logic          rxd_s;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;

    assign rxd_s = sync_q[1];

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // see pre-edge values and simulation matches the synthesised registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b11;
            tick_cnt_q <= '0;
        end else begin
            sync_q     <= {sync_q[0], bus.rxd};
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // ---------------- receive FSM ----------------
    state_t        state_q;
    logic [SW-1:0] sc_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          frame_err_q, overrun_q;
    logic          full_q, empty_q;
    logic          stop_sample, push, pop;

    // Stop-bit decision cycle; a push writes the FIFO on this same edge so the
    // byte is visible one clk after the sample, and a concurrent pop frees a
    // slot even when full.
    assign stop_sample = tick && (state_q == STOP) && (sc_q == SW'(OVERSAMPLE - 1));
    assign push        = stop_sample && rxd_s && (!full_q || bus.rd_en);
    assign pop         = bus.rd_en && !empty_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sc_q        <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        if (!rxd_s) begin
                            state_q <= START;
                            sc_q    <= '0;
                        end
                    end
                    START: begin
                        if (sc_q == SW'(OVERSAMPLE / 2 - 1)) begin
                            if (rxd_s) begin
                                state_q <= IDLE;          // false start, silent
                            end else begin
                                state_q   <= DATA;
                                sc_q      <= '0;
                                bit_idx_q <= '0;
                            end
                        end else begin
                            sc_q <= sc_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (sc_q == SW'(OVERSAMPLE - 1)) begin
                            shift_q   <= {rxd_s, shift_q[7:1]};   // LSB first
                            sc_q      <= '0;
                            bit_idx_q <= bit_idx_q + 1'b1;
                            if (bit_idx_q == 3'd7) state_q <= STOP;
                        end else begin
                            sc_q <= sc_q + 1'b1;
                        end
                    end
                    STOP: begin
                        if (sc_q == SW'(OVERSAMPLE - 1)) begin
                            // Return mid stop bit so a back-to-back start edge is caught.
                            state_q <= IDLE;
                            if (!rxd_s)                       frame_err_q <= 1'b1;
                            else if (full_q && !bus.rd_en)    overrun_q   <= 1'b1;
                        end else begin
                            sc_q <= sc_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_d, empty_d;
    logic [7:0]    data_q, data_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(FIFO_DEPTH));
        empty_d = (count_d == '0);
        // Registered show-ahead head: the incoming byte bypasses the array when
        // it becomes the head; otherwise hold when the FIFO drains.
        data_d = data_q;
        if (push && (rd_ptr_d == wr_ptr_q)) data_d = shift_q;
        else if (!empty_d)                  data_d = mem_q[rd_ptr_d];
    end

    // NOTE: the storage array has no reset; its contents are only observed
    // after a push, and leaving it unreset lets it map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            data_q   <= data_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.count     = count_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_os_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_os_fifo
//   Directed bench for uart_rx_os_fifo. The DUT runs at a raised baud rate
//   (TICK_DIV = 8, 128 clk per bit) so the 17-byte overrun scenario stays short;
//   oversampling and FIFO depth are at their defaults.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_os_fifo;
    localparam int CLOCK_FREQ = 12000000;
    localparam int BAUD_RATE  = 93750;
    localparam int OVERSAMPLE = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int TICK_DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);  // 8
    localparam int BIT        = TICK_DIV * OVERSAMPLE;                  // 128 clk
    localparam int LAT_MAX    = BIT * 19 / 2 + TICK_DIV + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_os_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    uart_rx_os_fifo #(
        .CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] pop_q [$];

    // Pulse counters and pop log, sampled on the active edge before flops update.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.frame_err) fe_cnt++;
            if (bus.overrun)   ov_cnt++;
            if (bus.rd_en && !bus.empty) pop_q.push_back(bus.data);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.rxd = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            idle(BIT);
        end
        bus.rxd = stop_bit;
        idle(BIT);
        bus.rxd = 1'b1;
    endtask

    task automatic pop_check(input logic [7:0] exp, input string name);
        n_vec++;
        if (bus.empty !== 1'b0 || bus.data !== exp) begin
            n_err++;
            $display("FAIL %s: empty=%b data=%02h, need empty=0 data=%02h", name, bus.empty, bus.data, exp);
        end
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        n_vec++; if (bus.data      !== 8'h00) begin n_err++; $display("FAIL %s data: %02h need 00", name, bus.data); end
        n_vec++; if (bus.empty     !== 1'b1)  begin n_err++; $display("FAIL %s empty: %b need 1", name, bus.empty); end
        n_vec++; if (bus.full      !== 1'b0)  begin n_err++; $display("FAIL %s full: %b need 0", name, bus.full); end
        n_vec++; if (bus.count     !== 5'd0)  begin n_err++; $display("FAIL %s count: %0d need 0", name, bus.count); end
        n_vec++; if (bus.frame_err !== 1'b0)  begin n_err++; $display("FAIL %s frame_err: %b need 0", name, bus.frame_err); end
        n_vec++; if (bus.overrun   !== 1'b0)  begin n_err++; $display("FAIL %s overrun: %b need 0", name, bus.overrun); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(4);
        check_reset_values("reset");
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_single_byte();
        int lat = 0;
        int fe0 = fe_cnt;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (bus.empty && lat < LAT_MAX) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        n_vec++; if (lat >= LAT_MAX) begin n_err++; $display("FAIL single latency: %0d clk, need < %0d", lat, LAT_MAX); end
        n_vec++; if (bus.count !== 5'd1) begin n_err++; $display("FAIL single count: %0d need 1", bus.count); end
        n_vec++; if (fe_cnt != fe0) begin n_err++; $display("FAIL single frame_err: %0d pulses need 0", fe_cnt - fe0); end
        pop_check(8'hA5, "single data");
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL single drain empty: %b need 1", bus.empty); end
        // Pop on empty must be ignored.
        bus.rd_en = 1'b1;
        idle(1);
        bus.rd_en = 1'b0;
        idle(1);
        n_vec++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
            n_err++; $display("FAIL underflow: count=%0d empty=%b need 0/1", bus.count, bus.empty);
        end
    endtask

    task automatic test_glitch();
        int fe0 = fe_cnt;
        bus.rxd = 1'b0;
        idle(BIT / 4);
        bus.rxd = 1'b1;
        idle(2 * BIT);
        n_vec++; if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            n_err++; $display("FAIL glitch push: empty=%b count=%0d need 1/0", bus.empty, bus.count);
        end
        n_vec++; if (fe_cnt != fe0) begin n_err++; $display("FAIL glitch frame_err: %0d pulses need 0", fe_cnt - fe0); end
    endtask

    task automatic test_bad_stop();
        int fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        idle(2 * BIT);
        n_vec++; if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL bad_stop pulses: %0d need 1", fe_cnt - fe0); end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL bad_stop empty: %b need 1", bus.empty); end
        send_frame(8'h12, 1'b1);
        idle(20);
        pop_check(8'h12, "bad_stop recovery");
        n_vec++; if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL bad_stop extra pulses: %0d need 1", fe_cnt - fe0); end
    endtask

    task automatic test_overrun();
        int ov0 = ov_cnt;
        for (int k = 0; k < 17; k++) begin
            send_frame(8'(k), 1'b1);
            idle(4);
            if (k == 14) begin
                n_vec++; if (bus.full !== 1'b0 || bus.count !== 5'd15) begin
                    n_err++; $display("FAIL overrun at 15: full=%b count=%0d need 0/15", bus.full, bus.count);
                end
            end
            if (k == 15) begin
                n_vec++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
                    n_err++; $display("FAIL overrun at 16: full=%b count=%0d need 1/16", bus.full, bus.count);
                end
                n_vec++; if (ov_cnt != ov0) begin n_err++; $display("FAIL overrun early pulse: %0d need 0", ov_cnt - ov0); end
            end
        end
        n_vec++; if (ov_cnt - ov0 != 1) begin n_err++; $display("FAIL overrun pulses: %0d need 1", ov_cnt - ov0); end
        n_vec++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL overrun count: %0d need 16", bus.count); end
        for (int k = 0; k < 16; k++) pop_check(8'(k), "overrun readback");
        n_vec++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 5'd0) begin
            n_err++; $display("FAIL overrun drain: empty=%b full=%b count=%0d need 1/0/0", bus.empty, bus.full, bus.count);
        end
    endtask

    task automatic test_back_to_back();
        pop_q.delete();
        bus.rd_en = 1'b1;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        idle(20);
        bus.rd_en = 1'b0;
        idle(2);
        n_vec++; if (pop_q.size() != 2) begin n_err++; $display("FAIL b2b count: %0d bytes need 2", pop_q.size()); end
        n_vec++; if (pop_q.size() < 1 || pop_q[0] !== 8'h55) begin
            n_err++; $display("FAIL b2b first: %02h need 55", (pop_q.size() > 0) ? pop_q[0] : 8'hxx);
        end
        n_vec++; if (pop_q.size() < 2 || pop_q[1] !== 8'hAA) begin
            n_err++; $display("FAIL b2b second: %02h need AA", (pop_q.size() > 1) ? pop_q[1] : 8'hxx);
        end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL b2b empty: %b need 1", bus.empty); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] partial = 8'hC3;
        send_frame(8'h77, 1'b1);      // leave one byte buffered
        idle(4);
        n_vec++; if (bus.count !== 5'd1) begin n_err++; $display("FAIL mid_reset preload count: %0d need 1", bus.count); end
        bus.rxd = 1'b0;
        idle(BIT);
        for (int i = 0; i < 3; i++) begin
            bus.rxd = partial[i];
            idle(BIT);
        end
        bus.rxd = partial[3];
        idle(BIT / 2);
        rst = 1'b1;
        bus.rxd = 1'b1;
        idle(3);
        check_reset_values("mid_reset");
        rst = 1'b0;
        idle(2 * BIT);
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL mid_reset stray byte: empty=%b need 1", bus.empty); end
        send_frame(8'h81, 1'b1);
        idle(20);
        pop_check(8'h81, "mid_reset next byte");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rxd   = 1'b1;
        bus.rd_en = 1'b0;
        test_reset();
        test_single_byte();
        test_glitch();
        test_bad_stop();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
